// File: rtl/l2_reqs_pbuf.sv
// l2_reqs_pbuf: parametrised L2 outstanding-request (MSHR) buffer.
// One entry per miss/upgrade: line address, unstable state and a signed
// invack counter. Outputs are combinational views of the registered table.
module l2_reqs_pbuf #(
    parameter int N_REQS     = 4,
    parameter int LADDR_BITS = 28,
    parameter int SET_BITS   = 9,
    parameter int STATE_BITS = 5,
    parameter int CNT_BITS   = 4,
    localparam int IDX_BITS  = $clog2(N_REQS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [LADDR_BITS-1:0] alloc_addr,
    input  logic [STATE_BITS-1:0] alloc_state,
    output logic [IDX_BITS-1:0]   alloc_idx,
    input  logic                  upd_valid,
    input  logic [IDX_BITS-1:0]   upd_idx,
    input  logic [STATE_BITS-1:0] upd_state,
    input  logic                  free_valid,
    input  logic [IDX_BITS-1:0]   free_idx,
    input  logic                  inv_set_valid,
    input  logic [IDX_BITS-1:0]   inv_set_idx,
    input  logic [CNT_BITS-1:0]   inv_set_cnt,
    input  logic                  inv_dec_valid,
    input  logic [IDX_BITS-1:0]   inv_dec_idx,
    input  logic [LADDR_BITS-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [IDX_BITS-1:0]   lookup_idx,
    output logic                  set_conflict,
    output logic [N_REQS-1:0]     inv_done,
    output logic [IDX_BITS:0]     occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);
    // Sum is two bits wider than the counter so set(min) + cnt(min) - 1 cannot wrap.
    localparam int SW = CNT_BITS + 2;
    localparam logic signed [SW-1:0] CNT_MIN = SW'(-(2 ** (CNT_BITS - 1)));
    localparam logic signed [SW-1:0] CNT_MAX = SW'((2 ** (CNT_BITS - 1)) - 1);
    localparam logic signed [SW-1:0] ONE     = SW'(1);

    logic [N_REQS-1:0]          valid;
    logic [N_REQS-1:0]          loaded;
    logic [LADDR_BITS-1:0]      addr  [N_REQS];
    logic [STATE_BITS-1:0]      state [N_REQS];
    logic signed [CNT_BITS-1:0] cnt   [N_REQS];

    logic signed [SW-1:0]       sum     [N_REQS];
    logic signed [CNT_BITS-1:0] cnt_nxt [N_REQS];
    logic [N_REQS-1:0]          set_hit, dec_hit, under;
    logic                       alloc_fire, err_ev;

    // An index names a live entry only if it is in range and that entry is valid.
    function automatic logic idx_live(input logic [IDX_BITS-1:0] idx,
                                      input logic [N_REQS-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_REQS; i++)
            if (idx == IDX_BITS'(i) && v[i]) r = 1'b1;
        return r;
    endfunction

    // Per-entry invack arithmetic: add loaded count, subtract one ack, clamp.
    always_comb begin
        for (int i = 0; i < N_REQS; i++) begin
            set_hit[i] = inv_set_valid && (inv_set_idx == IDX_BITS'(i));
            dec_hit[i] = inv_dec_valid && (inv_dec_idx == IDX_BITS'(i));
            sum[i]     = $signed({{2{cnt[i][CNT_BITS-1]}}, cnt[i]});
            if (set_hit[i])
                sum[i] = sum[i] + $signed({{2{inv_set_cnt[CNT_BITS-1]}}, inv_set_cnt});
            if (dec_hit[i])
                sum[i] = sum[i] - ONE;
            under[i]   = 1'b0;
            cnt_nxt[i] = sum[i][CNT_BITS-1:0];
            if (sum[i] < CNT_MIN) begin
                cnt_nxt[i] = CNT_MIN[CNT_BITS-1:0];
                under[i]   = 1'b1;
            end else if (sum[i] > CNT_MAX) begin
                cnt_nxt[i] = CNT_MAX[CNT_BITS-1:0];
            end
        end
    end

    // Table views: lowest free slot, lowest address hit, set conflict, counts.
    always_comb begin
        alloc_ready  = 1'b0;
        alloc_idx    = '0;
        lookup_hit   = 1'b0;
        lookup_idx   = '0;
        set_conflict = 1'b0;
        occupancy    = '0;
        for (int i = N_REQS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_ready = 1'b1;
                alloc_idx   = IDX_BITS'(i);
            end
            if (valid[i] && addr[i] == lookup_addr) begin
                lookup_hit = 1'b1;
                lookup_idx = IDX_BITS'(i);
            end
            if (valid[i] && addr[i][SET_BITS-1:0] == lookup_addr[SET_BITS-1:0])
                set_conflict = 1'b1;
            inv_done[i] = valid[i] && loaded[i] && (cnt[i] == '0);
            occupancy   = occupancy + (IDX_BITS+1)'(valid[i]);
        end
        full  = (occupancy == (IDX_BITS+1)'(N_REQS));
        empty = (occupancy == '0);
    end

    // Protocol violations this cycle: ops on dead entries or counter underflow.
    always_comb begin
        alloc_fire = alloc_valid && alloc_ready;
        err_ev = (free_valid    && !idx_live(free_idx, valid))
              || (upd_valid     && !idx_live(upd_idx, valid))
              || (inv_set_valid && !idx_live(inv_set_idx, valid))
              || (inv_dec_valid && !idx_live(inv_dec_idx, valid))
              || |(under & valid & (set_hit | dec_hit));
    end

    // Table update; free is written last so it overrides update/invack on its entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            loaded <= '0;
            err    <= 1'b0;
            for (int i = 0; i < N_REQS; i++) begin
                addr[i]  <= '0;
                state[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            if (err_ev) err <= 1'b1;
            for (int i = 0; i < N_REQS; i++) begin
                if (alloc_fire && alloc_idx == IDX_BITS'(i)) begin
                    valid[i]  <= 1'b1;
                    addr[i]   <= alloc_addr;
                    state[i]  <= alloc_state;
                    cnt[i]    <= '0;
                    loaded[i] <= 1'b0;
                end
                if (valid[i] && upd_valid && upd_idx == IDX_BITS'(i))
                    state[i] <= upd_state;
                if (valid[i] && (set_hit[i] || dec_hit[i])) begin
                    cnt[i] <= cnt_nxt[i];
                    if (set_hit[i]) loaded[i] <= 1'b1;
                end
                if (valid[i] && free_valid && free_idx == IDX_BITS'(i)) begin
                    valid[i]  <= 1'b0;
                    loaded[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_reqs_pbuf.sv
// tb_l2_reqs_pbuf: directed scenarios plus random traffic, checked against an
// array/integer model of the request table through an expectation queue.
module tb_l2_reqs_pbuf;
    localparam int N  = 4;
    localparam int LB = 28;
    localparam int SB = 9;
    localparam int STB = 5;
    localparam int CB = 4;
    localparam int IB = 2;
    localparam int CMIN = -(1 << (CB - 1));
    localparam int CMAX = (1 << (CB - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    logic alloc_valid, alloc_ready;
    logic [LB-1:0] alloc_addr;
    logic [STB-1:0] alloc_state;
    logic [IB-1:0] alloc_idx;
    logic upd_valid;
    logic [IB-1:0] upd_idx;
    logic [STB-1:0] upd_state;
    logic free_valid;
    logic [IB-1:0] free_idx;
    logic inv_set_valid;
    logic [IB-1:0] inv_set_idx;
    logic [CB-1:0] inv_set_cnt;
    logic inv_dec_valid;
    logic [IB-1:0] inv_dec_idx;
    logic [LB-1:0] lookup_addr;
    logic lookup_hit;
    logic [IB-1:0] lookup_idx;
    logic set_conflict;
    logic [N-1:0] inv_done;
    logic [IB:0] occupancy;
    logic full, empty, err;

    l2_reqs_pbuf dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_addr(alloc_addr), .alloc_state(alloc_state), .alloc_idx(alloc_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
        .free_valid(free_valid), .free_idx(free_idx),
        .inv_set_valid(inv_set_valid), .inv_set_idx(inv_set_idx), .inv_set_cnt(inv_set_cnt),
        .inv_dec_valid(inv_dec_valid), .inv_dec_idx(inv_dec_idx),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
        .set_conflict(set_conflict), .inv_done(inv_done), .occupancy(occupancy),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic av; logic [LB-1:0] aa; logic [STB-1:0] as;
        logic uv; logic [IB-1:0] ui; logic [STB-1:0] us;
        logic fv; logic [IB-1:0] fi;
        logic sv; logic [IB-1:0] si; logic [CB-1:0] sc;
        logic dv; logic [IB-1:0] di;
        logic [LB-1:0] la;
    } stim_t;

    typedef struct {
        logic ready; logic [IB-1:0] aidx;
        logic hit; logic [IB-1:0] lidx; logic conf;
        logic [N-1:0] done; logic [IB:0] occ;
        logic full; logic empty; logic err;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int fails = 0;

    // Reference table
    bit m_valid[N];
    bit m_loaded[N];
    logic [LB-1:0] m_addr[N];
    int m_cnt[N];
    bit m_err;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_loaded[i] = 0; m_cnt[i] = 0; m_addr[i] = '0;
        end
        m_err = 0;
    endfunction

    function automatic exp_t expect_of(logic [LB-1:0] la);
        exp_t e;
        int occ;
        e = '{default: '0};
        occ = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m_valid[i]) begin e.ready = 1; e.aidx = IB'(i); end
            if (m_valid[i] && m_addr[i] == la) begin e.hit = 1; e.lidx = IB'(i); end
            if (m_valid[i] && m_addr[i][SB-1:0] == la[SB-1:0]) e.conf = 1;
            e.done[i] = m_valid[i] && m_loaded[i] && m_cnt[i] == 0;
            if (m_valid[i]) occ++;
        end
        e.occ = (IB+1)'(occ);
        e.full = (occ == N);
        e.empty = (occ == 0);
        e.err = m_err;
        return e;
    endfunction

    function automatic void model_step(stim_t s);
        bit v0[N];
        int lo, c, d, sval;
        bit t;
        if (s.r) begin model_reset(); return; end
        v0 = m_valid;
        sval = $signed(s.sc);
        lo = -1;
        for (int i = 0; i < N; i++) if (!v0[i] && lo < 0) lo = i;
        if (s.av && lo >= 0) begin
            m_valid[lo] = 1; m_addr[lo] = s.aa; m_cnt[lo] = 0; m_loaded[lo] = 0;
        end
        if (s.uv && !v0[s.ui]) m_err = 1;
        if (s.sv && !v0[s.si]) m_err = 1;
        if (s.dv && !v0[s.di]) m_err = 1;
        for (int i = 0; i < N; i++) begin
            if (v0[i]) begin
                d = 0; t = 0;
                if (s.sv && s.si == IB'(i)) begin d += sval; t = 1; m_loaded[i] = 1; end
                if (s.dv && s.di == IB'(i)) begin d -= 1; t = 1; end
                if (t) begin
                    c = m_cnt[i] + d;
                    if (c < CMIN) begin c = CMIN; m_err = 1; end
                    if (c > CMAX) c = CMAX;
                    m_cnt[i] = c;
                end
            end
        end
        if (s.fv) begin
            if (v0[s.fi]) begin m_valid[s.fi] = 0; m_loaded[s.fi] = 0; end
            else m_err = 1;
        end
    endfunction

    task automatic drive(stim_t s);
        rst = s.r;
        alloc_valid = s.av; alloc_addr = s.aa; alloc_state = s.as;
        upd_valid = s.uv; upd_idx = s.ui; upd_state = s.us;
        free_valid = s.fv; free_idx = s.fi;
        inv_set_valid = s.sv; inv_set_idx = s.si; inv_set_cnt = s.sc;
        inv_dec_valid = s.dv; inv_dec_idx = s.di;
        lookup_addr = s.la;
    endtask

    // Apply one cycle of stimulus; the expectation for this cycle's outputs is queued.
    task automatic do_cycle(stim_t s);
        drive(s);
        exp_q.push_back(expect_of(s.la));
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
        vectors++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({alloc_ready, alloc_idx, lookup_hit, lookup_idx, set_conflict,
                     inv_done, occupancy, full, empty, err} !==
                    {e.ready, e.aidx, e.hit, e.lidx, e.conf, e.done, e.occ,
                     e.full, e.empty, e.err}) begin
                    fails++;
                    $display("FAIL sb at %0t: got rdy%b aidx%0d hit%b lidx%0d conf%b done%b occ%0d full%b empty%b err%b; expected rdy%b aidx%0d hit%b lidx%0d conf%b done%b occ%0d full%b empty%b err%b",
                             $time, alloc_ready, alloc_idx, lookup_hit, lookup_idx, set_conflict,
                             inv_done, occupancy, full, empty, err,
                             e.ready, e.aidx, e.hit, e.lidx, e.conf, e.done, e.occ,
                             e.full, e.empty, e.err);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int u, st;
        drive(idle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_aidx", 32'(alloc_idx), 0);
        chk("rst_done", 32'(inv_done), 0);
        chk("rst_hit", 32'(lookup_hit), 0);

        // Fill the table
        for (int k = 0; k < 4; k++) begin
            chk("fill_aidx", 32'(alloc_idx), 32'(k));
            s = idle(); s.av = 1; s.aa = LB'(32'h100 + k); s.as = STB'(k);
            do_cycle(s);
        end
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_occ", 32'(occupancy), 4);

        // Free + alloc on a full table: alloc must not be taken
        s = idle(); s.fv = 1; s.fi = 2; s.av = 1; s.aa = 28'h555;
        do_cycle(s);
        chk("fa_ready", 32'(alloc_ready), 1);
        chk("fa_aidx", 32'(alloc_idx), 2);
        chk("fa_occ", 32'(occupancy), 3);

        // Re-populate entry 1 with 0xA05
        s = idle(); s.fv = 1; s.fi = 1; do_cycle(s);
        s = idle(); s.av = 1; s.aa = 28'h0000A05; do_cycle(s);
        s = idle(); s.la = 28'h0000A05; do_cycle(s);
        chk("lk_hit", 32'(lookup_hit), 1);
        chk("lk_idx", 32'(lookup_idx), 1);
        s = idle(); s.la = 28'h0001A05; do_cycle(s);
        chk("lk_miss", 32'(lookup_hit), 0);
        chk("lk_conf", 32'(set_conflict), 1);

        // Early invacks on entry 0, then count load with same-cycle ack
        s = idle(); s.dv = 1; s.di = 0; do_cycle(s); do_cycle(s);
        chk("inv_early", 32'(inv_done[0]), 0);
        s = idle(); s.sv = 1; s.si = 0; s.sc = 4'd3; s.dv = 1; s.di = 0; do_cycle(s);
        chk("inv_done0", 32'(inv_done[0]), 1);
        chk("inv_err", 32'(err), 0);

        // Update + free same entry: free wins
        s = idle(); s.uv = 1; s.ui = 0; s.us = 5'h1f; s.fv = 1; s.fi = 0; s.la = 28'h100;
        do_cycle(s);
        chk("uf_hit", 32'(lookup_hit), 0);
        chk("uf_occ", 32'(occupancy), 2);
        chk("uf_done", 32'(inv_done[0]), 0);
        chk("uf_err", 32'(err), 0);

        // Free of an invalid entry
        s = idle(); s.fv = 1; s.fi = 2; do_cycle(s);
        chk("bad_free_err", 32'(err), 1);
        s = idle(); s.av = 1; s.aa = 28'h200; do_cycle(s);
        chk("three_occ", 32'(occupancy), 3);

        // Reset with live entries
        s = idle(); s.r = 1; s.la = 28'h0000A05; do_cycle(s);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_done", 32'(inv_done), 0);
        chk("mid_rst_hit", 32'(lookup_hit), 0);
        chk("mid_rst_err", 32'(err), 0);

        // Free on empty table -> sticky err
        s = idle(); s.fv = 1; s.fi = 3; do_cycle(s);
        chk("empty_free_err", 32'(err), 1);
        s = idle(); repeat (3) do_cycle(s);
        chk("err_sticky", 32'(err), 1);
        s = idle(); s.r = 1; do_cycle(s);

        // Random traffic on a small address pool so hits and conflicts are common
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.r  = ($urandom_range(0, 255) == 0);
            s.av = ($urandom_range(0, 1) == 0);
            u = $urandom_range(0, 1); st = $urandom_range(0, 3);
            s.aa = (LB'(u) << SB) | LB'(st);
            s.as = STB'($urandom);
            s.uv = ($urandom_range(0, 9) < 3); s.ui = IB'($urandom); s.us = STB'($urandom);
            s.fv = ($urandom_range(0, 9) < 3); s.fi = IB'($urandom);
            s.sv = ($urandom_range(0, 9) < 2); s.si = IB'($urandom);
            s.sc = CB'($urandom_range(0, 3));
            s.dv = ($urandom_range(0, 9) < 4); s.di = IB'($urandom);
            u = $urandom_range(0, 1); st = $urandom_range(0, 3);
            s.la = (LB'(u) << SB) | LB'(st);
            do_cycle(s);
        end

        drive(idle());
        @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
